bit_ser_tx: RTL and testbench
=============================

# bit_ser_tx

Parallel-to-serial transmitter for the bit-serial datapath. Accepts a WIDTH-bit word on a valid/ready handshake and emits it LSB-first, one bit per cycle. Each bit comes with a shift strobe, so a downstream serial register captures it directly. On the MSB it flags last-bit and, for signed words, the sign path. It is the writer side feeding the serial general-purpose register file.

## Interface
Parameters:
- WIDTH, 8, word length in bits (≥2)
- CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden)

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  producer has a word on i_data
- i_data  in  WIDTH  parallel word
- i_signed  in  1  word is two's complement; sampled with i_data
- o_ready  out  1  transmitter can accept a word this cycle
- i_hold  in  1  consumer stall; freezes serialisation
- o_bit  out  1  current serial bit, LSB first
- o_shift  out  1  o_bit is valid this cycle; consumer shifts on it
- o_last  out  1  current bit is the MSB; qualified by o_shift
- o_sign  out  1  o_last of a signed word; consumer takes sign path
- o_busy  out  1  a word is being serialised (SHIFT state)

## Operation
- FSM states: IDLE and SHIFT. Reset enters IDLE.
- IDLE:
  - o_ready=1.
  - Transfer when i_valid & o_ready: the shift register loads i_data, the sign flag loads i_signed, the counter clears, and the FSM moves to SHIFT.
- SHIFT:
  - o_bit = shreg[0].
  - o_shift = ~i_hold.
  - o_last = o_shift & (cnt==WIDTH-1).
  - o_sign = o_last & sign flag.
- On each o_shift cycle: shreg shifts right by one, cnt increments.
- On an o_last cycle: cnt wraps to 0 and the FSM returns to IDLE (or reloads; see Configuration).
- i_hold=1:
  - shreg, cnt and state are frozen.
  - o_bit keeps its value.
  - o_shift, o_last and o_sign are 0.
- o_ready depends only on registered state, never on i_valid or i_hold.
- A word is never dropped or duplicated. Exactly WIDTH o_shift pulses occur per accepted word.
- i_data is ignored when no transfer occurs.

## Timing
- Reset values: o_ready=1, o_bit=0, o_shift=0, o_last=0, o_sign=0, o_busy=0. The shift register, counter and sign flag are all 0.
- Latency: transfer at edge N; bit0 appears with o_shift in the cycle after edge N. With no hold, the MSB is output WIDTH-1 cycles later.
- Throughput without prefetch: WIDTH+1 cycles per word (one IDLE cycle between words).
- Reset asserted mid-word: the word is abandoned and all outputs go to reset values immediately (asynchronous). No partial word is resumed.
- i_hold asserted on the last-bit cycle: the IDLE transition waits until the hold releases.

## Configuration
- Macro BIT_SER_TX_PREFETCH_EN.
- Without it:
  - No holding register.
  - o_ready=1 only in IDLE.
  - Throughput is WIDTH+1 cycles per word.
- With it:
  - One-entry holding register (data + signed flag) plus a full flag.
  - o_ready = ~full, including during SHIFT.
  - On an o_last cycle with the holding register full: the holding word moves into shreg, full clears, and the FSM stays in SHIFT. Back-to-back words stream with zero bubble (WIDTH cycles per word).
  - On an o_last cycle with full=0 and a transfer in that same cycle: the incoming word loads shreg directly and the FSM stays in SHIFT.
  - IDLE with full=0: a transfer loads shreg directly.
  - Reset clears full.

## Structure
- Shared package bit_ser_pkg:
  - typedef state_e {IDLE, SHIFT}.
  - Default WIDTH constant, shared with the serial register file.
- Optional sub-module bit_ser_hold: the one-entry holding register with full flag. Instantiated only under BIT_SER_TX_PREFETCH_EN.
- The FSM, counter and shift register stay in bit_ser_tx.

## Test plan
- Basic serialisation:
  - Stimulus: reset, then send 8'hB5 unsigned.
  - Required: o_bit sequence 1,0,1,0,1,1,0,1 on 8 consecutive o_shift cycles; o_last only on the 8th; o_sign=0 throughout; o_ready returns 1 in the following cycle.
- Signed word:
  - Stimulus: send 8'h80 with i_signed=1.
  - Required: seven 0 bits, then 1 with o_last=1 and o_sign=1.
- Hold:
  - Stimulus: send 8'h0F; assert i_hold for 3 cycles after bit 2.
  - Required: no o_shift for those cycles; o_bit holds 1; resumes with bit 3=1; 8 o_shift pulses total.
- Reset mid-word:
  - Stimulus: deassert i_rst_n after bit 4 of 8'hFF.
  - Required: all outputs at reset values at once. A new word 8'h01 sent after reset serialises cleanly.
- Back-to-back, 100 random words with i_valid always high:
  - Required: the output bitstream equals the inputs.
  - Without the macro: 9 cycles per word.
  - With BIT_SER_TX_PREFETCH_EN: 8 cycles per word and no gap in o_shift.
- Prefetch corner (macro on):
  - Stimulus: a transfer coincides with o_last while the holding register is empty.
  - Required: the next word's bit0 follows in the very next cycle.

Source files
------------

// File: rtl/bit_ser_pkg.sv
// Shared definitions for the bit-serial datapath (transmitter and serial register file).
package bit_ser_pkg;

  localparam int BIT_SER_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bit_ser_tx_if.sv
// Word-in / bit-out bundle of the serial transmitter; slave is the transmitter side.
interface bit_ser_tx_if #(
  parameter int WIDTH = bit_ser_pkg::BIT_SER_WIDTH
);
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             i_signed;
  logic             o_ready;
  logic             i_hold;
  logic             o_bit;
  logic             o_shift;
  logic             o_last;
  logic             o_sign;
  logic             o_busy;

  modport master (
    output i_valid, i_data, i_signed, i_hold,
    input  o_ready, o_bit, o_shift, o_last, o_sign, o_busy
  );

  modport slave (
    input  i_valid, i_data, i_signed, i_hold,
    output o_ready, o_bit, o_shift, o_last, o_sign, o_busy
  );
endinterface

// File: rtl/bit_ser_hold.sv
// One-entry holding register (word + signed flag) with full flag; push wins over pop,
// the producer never pushes while full because the ready it sees is ~full.
module bit_ser_hold
  import bit_ser_pkg::*;
#(
  parameter int WIDTH = BIT_SER_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_signed,
  input  logic             i_pop,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data,
  output logic             o_signed
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             r_signed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full   <= 1'b0;
      r_data   <= '0;
      r_signed <= 1'b0;
    end else if (i_push) begin
      r_full   <= 1'b1;
      r_data   <= i_data;
      r_signed <= i_signed;
    end else if (i_pop) begin
      r_full   <= 1'b0;
    end
  end

  assign o_full   = r_full;
  assign o_data   = r_data;
  assign o_signed = r_signed;

endmodule

// File: rtl/bit_ser_tx.sv
// Parallel-to-serial transmitter, LSB first; bit0 appears the cycle after the transfer, i_hold freezes it.
// BIT_SER_TX_PREFETCH_EN adds a one-entry holding register so words stream with no idle cycle.
module bit_ser_tx
  import bit_ser_pkg::*;
#(
  parameter  int WIDTH = BIT_SER_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  bit_ser_tx_if.slave  bus
);

  state_e           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign;

  logic             w_ready;
  logic             w_xfer;
  logic             w_shift;
  logic             w_last;
  logic             w_reload;
  logic [WIDTH-1:0] w_next_data;
  logic             w_next_signed;

  assign w_shift = (r_state == SHIFT) && !bus.i_hold;
  assign w_last  = w_shift && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_xfer  = bus.i_valid && w_ready;

`ifdef BIT_SER_TX_PREFETCH_EN
  logic             w_full;
  logic [WIDTH-1:0] w_hold_data;
  logic             w_hold_signed;
  logic             w_push;
  logic             w_pop;

  // A word arriving on the last-bit cycle with the holder empty bypasses it.
  assign w_push = w_xfer && (r_state == SHIFT) && !w_last;
  assign w_pop  = w_last && w_full;

  bit_ser_hold #(.WIDTH(WIDTH)) u_hold (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_push   (w_push),
    .i_data   (bus.i_data),
    .i_signed (bus.i_signed),
    .i_pop    (w_pop),
    .o_full   (w_full),
    .o_data   (w_hold_data),
    .o_signed (w_hold_signed)
  );

  assign w_ready       = !w_full;
  assign w_reload      = w_full || w_xfer;
  assign w_next_data   = w_full ? w_hold_data   : bus.i_data;
  assign w_next_signed = w_full ? w_hold_signed : bus.i_signed;
`else
  assign w_ready       = (r_state == IDLE);
  assign w_reload      = 1'b0;
  assign w_next_data   = bus.i_data;
  assign w_next_signed = bus.i_signed;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_shreg <= bus.i_data;
            r_sign  <= bus.i_signed;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_cnt <= '0;
            if (w_reload) begin
              r_shreg <= w_next_data;
              r_sign  <= w_next_signed;
            end else begin
              // Zero fill leaves o_bit low while idle.
              r_shreg <= r_shreg >> 1;
              r_state <= IDLE;
            end
          end else if (w_shift) begin
            r_shreg <= r_shreg >> 1;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_bit   = r_shreg[0];
  assign bus.o_shift = w_shift;
  assign bus.o_last  = w_last;
  assign bus.o_sign  = w_last && r_sign;
  assign bus.o_busy  = (r_state == SHIFT);

endmodule

// File: tb/tb_bit_ser_tx.sv
// Directed bench for bit_ser_tx: drive at falling edge, sample 1ns later.
module tb_bit_ser_tx;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bit_ser_tx_if #(.WIDTH(8)) bus();

  bit_ser_tx #(.WIDTH(8)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.o_ready, bus.o_bit, bus.o_shift, bus.o_last, bus.o_sign, bus.o_busy};
  endfunction

  // Sends one word from IDLE and collects its bits; hold_at = bit index to stall before.
  task automatic send_word(input logic [7:0] d, input logic sgn, input int hold_at, input int hold_len);
    int         waited = 0;
    int         n      = 0;
    int         cyc    = 0;
    int         held   = 0;
    logic [7:0] rxw    = '0;
    logic [7:0] lastm  = '0;
    logic [7:0] signm  = '0;
    while (!bus.o_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_wait", waited, 0);
    bus.i_valid  = 1'b1;
    bus.i_data   = d;
    bus.i_signed = sgn;
    @(negedge clk);
    bus.i_valid  = 1'b0;
    bus.i_data   = 8'h5A;
    bus.i_signed = 1'b1;
    while (n < 8 && cyc < 40) begin
      bus.i_hold = (n == hold_at) && (held < hold_len);
      #1;
      if (bus.i_hold) begin
        held++;
        chk("hold_shift", bus.o_shift, 0);
        chk("hold_last", bus.o_last, 0);
        chk("hold_bit", bus.o_bit, d[n]);
      end else begin
        chk("shift_strobe", bus.o_shift, 1);
        chk("busy", bus.o_busy, 1);
        if (bus.o_shift) begin
          rxw[n]   = bus.o_bit;
          lastm[n] = bus.o_last;
          signm[n] = bus.o_sign;
          n++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_hold = 1'b0;
    #1;
    chk("shift_count", n, 8);
    chk("hold_cycles", held, hold_len);
    chk("bits", rxw, d);
    chk("last_mask", lastm, 8'h80);
    chk("sign_mask", signm, sgn ? 8'h80 : 8'h00);
    chk("ready_after", bus.o_ready, 1);
    chk("busy_after", bus.o_busy, 0);
  endtask

  initial begin
    logic [7:0] words [100];
    logic [7:0] rx;
    logic [7:0] wb;
    int         sent;
    int         nbits;
    int         first;
    int         lastc;
    int         gaps;
    int         cyc;

    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_data   = 8'h00;
    bus.i_signed = 1'b0;
    bus.i_hold   = 1'b0;
    #1;
    chk("reset_outputs", outs(), 6'b100000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_word(8'hB5, 1'b0, -1, 0);
    send_word(8'h80, 1'b1, -1, 0);
    send_word(8'h0F, 1'b0, 3, 3);

    // Reset while bit 4 of 0xFF is on the line.
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_data   = 8'hFF;
    bus.i_signed = 1'b1;
    @(negedge clk);
    bus.i_valid  = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_shift", bus.o_shift, 1);
    chk("pre_rst_bit", bus.o_bit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", outs(), 6'b100000);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_held", outs(), 6'b100000);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(8'h01, 1'b0, -1, 0);

`ifdef BIT_SER_TX_PREFETCH_EN
    // Transfer on the last-bit cycle with the holder empty.
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_data   = 8'h3C;
    bus.i_signed = 1'b0;
    @(negedge clk);
    bus.i_valid  = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    chk("pf_a_last", bus.o_last, 1);
    chk("pf_ready_on_last", bus.o_ready, 1);
    wb           = 8'hA6;
    bus.i_valid  = 1'b1;
    bus.i_data   = wb;
    bus.i_signed = 1'b1;
    @(negedge clk);
    bus.i_valid  = 1'b0;
    bus.i_signed = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("pf_shift", bus.o_shift, 1);
      chk("pf_bit", bus.o_bit, wb[k]);
      chk("pf_last", bus.o_last, (k == 7) ? 1 : 0);
      chk("pf_sign", bus.o_sign, (k == 7) ? 1 : 0);
      @(negedge clk);
      #1;
    end
`endif

    // Back-to-back stream with i_valid high throughout.
    for (int i = 0; i < 100; i++) words[i] = 8'($urandom);
    sent  = 0;
    nbits = 0;
    first = -1;
    lastc = -1;
    gaps  = 0;
    cyc   = 0;
    rx    = '0;
    while (nbits < 800 && cyc < 3000) begin
      @(negedge clk);
      bus.i_valid  = (sent < 100);
      bus.i_data   = (sent < 100) ? words[sent] : 8'h00;
      bus.i_signed = 1'b0;
      #1;
      if (bus.o_shift) begin
        if (first < 0) first = cyc;
        rx[nbits % 8] = bus.o_bit;
        nbits++;
        if (nbits % 8 == 0) chk("stream_word", rx, words[nbits / 8 - 1]);
        if (bus.o_last) lastc = cyc;
      end else if (first >= 0) begin
        gaps++;
      end
      if (bus.o_ready && sent < 100) sent++;
      cyc++;
    end
    bus.i_valid = 1'b0;
    chk("stream_bits", nbits, 800);
`ifdef BIT_SER_TX_PREFETCH_EN
    chk("stream_span", lastc - first + 1, 800);
    chk("stream_gaps", gaps, 0);
`else
    chk("stream_span", lastc - first + 1, 899);
    chk("stream_gaps", gaps, 99);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
